// File: rtl/pu_ctrl_pkg.sv
// Shared types and constants for the PU round controller and its helpers.
package pu_ctrl_pkg;

    localparam int NUM_PU   = 4;
    localparam int PU_IDX_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EVAL,
        STEP,
        DONE
    } state_t;

endpackage

// File: rtl/pu_survivor_enc.sv
// Combinational decode of the PU zero flags: finds a lone survivor (exactly one
// PU still non-zero) and flags the case where every PU has reached zero.
module pu_survivor_enc
    import pu_ctrl_pkg::*;
(
    input  logic [NUM_PU-1:0]   pu_zero,
    output logic                is_unique,
    output logic                all_zero,
    output logic [PU_IDX_W-1:0] idx
);

    logic [2:0] clear_cnt;

    // Count the PUs that are still non-zero and remember the index of the last one seen;
    // the index is only meaningful when exactly one bit is clear.
    always_comb begin
        clear_cnt = '0;
        idx       = '0;
        for (int i = 0; i < NUM_PU; i++) begin
            if (!pu_zero[i]) begin
                clear_cnt = clear_cnt + 3'd1;
                idx       = PU_IDX_W'(i);
            end
        end
    end

    assign is_unique = (clear_cnt == 3'd1);
    assign all_zero  = &pu_zero;

endmodule

// File: rtl/pu_round_controller.sv
// Sequencing FSM for the four-PU elimination datapath. A round loads the PUs,
// then alternates EVAL and STEP until a single survivor remains, every PU is
// zero, or the step budget is exhausted. MAX_ITER must fit in ITER_W bits.
module pu_round_controller
    import pu_ctrl_pkg::*;
#(
    parameter int MAX_ITER = 15,
    parameter int ITER_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_PU-1:0]   pu_zero,
    output logic                ready,
    output logic                pu_load,
    output logic                pu_step,
    output logic                done,
    output logic [PU_IDX_W-1:0] winner,
    output logic                error,
    output logic [ITER_W-1:0]   iter_count
);

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    state_t                state;
    logic                  enc_unique;
    logic                  enc_all_zero;
    logic [PU_IDX_W-1:0]   enc_idx;

    pu_survivor_enc u_enc (
        .pu_zero   (pu_zero),
        .is_unique (enc_unique),
        .all_zero  (enc_all_zero),
        .idx       (enc_idx)
    );

    // ready depends only on the state register, so it is high throughout reset.
    assign ready = (state == IDLE);

    // Round sequencer: pulses are registered alongside the state transition that
    // produces them, so each pulse lines up exactly with the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            iter_count <= '0;
            winner     <= '0;
            error      <= 1'b0;
            pu_load    <= 1'b0;
            pu_step    <= 1'b0;
            done       <= 1'b0;
        end else begin
            pu_load <= 1'b0;
            pu_step <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        pu_load    <= 1'b1;
                        iter_count <= '0;
                        winner     <= '0;
                        error      <= 1'b0;
                    end
                end
                LOAD: begin
                    state <= EVAL;
                end
                EVAL: begin
                    if (enc_unique) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        winner <= enc_idx;
                        error  <= 1'b0;
                    end else if (enc_all_zero) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        winner <= '0;
                        error  <= 1'b1;
                    end else if (iter_count == ITER_LIMIT) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        winner <= '0;
                        error  <= 1'b1;
                    end else begin
                        state   <= STEP;
                        pu_step <= 1'b1;
                        if (iter_count != ITER_LIMIT) begin
                            iter_count <= iter_count + 1'b1;
                        end
                    end
                end
                STEP: begin
                    state <= EVAL;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pu_round_controller.sv
// Self-checking bench for pu_round_controller: a scoreboard of expected round
// outcomes, filled by the stimulus tasks from a reference model and drained by
// a monitor whenever the controller raises done.
module tb_pu_round_controller;

    localparam int MAX_ITER = 15;
    localparam int ITER_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [3:0]        pu_zero;
    logic              ready;
    logic              pu_load;
    logic              pu_step;
    logic              done;
    logic [1:0]        winner;
    logic              error;
    logic [ITER_W-1:0] iter_count;

    pu_round_controller #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pu_zero    (pu_zero),
        .ready      (ready),
        .pu_load    (pu_load),
        .pu_step    (pu_step),
        .done       (done),
        .winner     (winner),
        .error      (error),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to timestamp pulses.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int load_cyc;
        int done_cyc;
        int winner;
        int error;
        int iter;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] cur_seq [0:MAX_ITER];
    int         total = 0;
    int         bad = 0;
    int         prev_winner = 0;
    int         prev_error = 0;
    int         prev_iter = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: walk the per-EVAL pu_zero values in order and apply the
    // round rules directly (lone survivor, then all zero, then budget).
    function automatic exp_t model_round();
        exp_t e;
        e.load_cyc = 0;
        e.done_cyc = 0;
        e.winner   = 0;
        e.error    = 1;
        e.iter     = MAX_ITER;
        for (int k = 0; k <= MAX_ITER; k++) begin
            logic [3:0] v;
            v = cur_seq[k];
            if ($countones(~v) == 1) begin
                for (int i = 0; i < 4; i++) if (!v[i]) e.winner = i;
                e.error = 0;
                e.iter  = k;
                return e;
            end else if (v == 4'b1111 || k == MAX_ITER) begin
                e.winner = 0;
                e.error  = 1;
                e.iter   = k;
                return e;
            end
        end
        return e;
    endfunction

    function automatic void fill_seq(input logic [3:0] v);
        for (int k = 0; k <= MAX_ITER; k++) cur_seq[k] = v;
    endfunction

    function automatic void random_seq();
        bit biased;
        biased = ($urandom_range(0, 4) == 0);
        for (int k = 0; k <= MAX_ITER; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (biased) begin
                logic [3:0] two_clear [6];
                two_clear = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};
                cur_seq[k] = (r < 5) ? 4'b0000 : two_clear[$urandom_range(0, 5)];
            end else if (r < 3) begin
                cur_seq[k] = 4'b0000;
            end else if (r < 9) begin
                cur_seq[k] = 4'($urandom);
            end else begin
                cur_seq[k] = 4'b1111;
            end
        end
    endfunction

    // Run one round from IDLE using cur_seq as the pu_zero value at each EVAL.
    // pu_zero is randomised outside EVAL and start is poked while busy; with
    // hold set, start stays high so the next round begins straight after DONE.
    task automatic applyStimulus(input bit hold);
        exp_t e;
        int   s;
        int   last;
        @(negedge clk);
        checkOutput("idle_ready", int'(ready), 1);
        checkOutput("held_winner", int'(winner), prev_winner);
        checkOutput("held_error", int'(error), prev_error);
        checkOutput("held_iter", int'(iter_count), prev_iter);
        start   = 1'b1;
        pu_zero = 4'($urandom);
        @(negedge clk);
        s = cyc;
        checkOutput("load_pulse", int'(pu_load), 1);
        checkOutput("load_not_ready", int'(ready), 0);
        checkOutput("cleared_winner", int'(winner), 0);
        checkOutput("cleared_error", int'(error), 0);
        checkOutput("cleared_iter", int'(iter_count), 0);
        e = model_round();
        e.load_cyc = s;
        e.done_cyc = s + 2 + 2 * e.iter;
        sb.push_back(e);
        last = 3 + 2 * e.iter;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) @(negedge clk);
            if (c % 2 == 0) pu_zero = cur_seq[(c - 2) / 2];
            else            pu_zero = 4'($urandom);
            if (hold)                      start = 1'b1;
            else if (c >= 2 && c < last)   start = ($urandom_range(0, 2) == 0);
            else                           start = 1'b0;
        end
        prev_winner = e.winner;
        prev_error  = e.error;
        prev_iter   = e.iter;
    endtask

    // Abort a round with reset while the third STEP pulse is out.
    task automatic resetMidRound();
        fill_seq(4'b0000);
        @(negedge clk);
        start   = 1'b1;
        pu_zero = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("pre_reset_step", int'(pu_step), 1);
        checkOutput("pre_reset_iter", int'(iter_count), 3);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", int'(ready), 1);
        checkOutput("abort_iter", int'(iter_count), 0);
        checkOutput("abort_step", int'(pu_step), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_load", int'(pu_load), 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_winner = 0;
        prev_error  = 0;
        prev_iter   = 0;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: timestamps pu_load, counts pu_step pulses and checks each done
    // against the oldest scoreboard entry.
    int step_cnt = 0;
    int load_cyc = -1;
    always @(negedge clk) begin
        if (rst_n) begin
            if (pu_load) begin
                load_cyc <= cyc;
                step_cnt <= 0;
            end else if (pu_step) begin
                step_cnt <= step_cnt + 1;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("done_cycle", cyc, e.done_cyc);
                    checkOutput("load_cycle", load_cyc, e.load_cyc);
                    checkOutput("winner", int'(winner), e.winner);
                    checkOutput("error", int'(error), e.error);
                    checkOutput("iter_count", int'(iter_count), e.iter);
                    checkOutput("step_pulses", step_cnt, e.iter);
                    checkOutput("done_not_ready", int'(ready), 0);
                end
            end
        end else begin
            step_cnt <= 0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        pu_zero = 4'b0000;
        #1;
        checkOutput("rst_ready", int'(ready), 1);
        checkOutput("rst_load", int'(pu_load), 0);
        checkOutput("rst_step", int'(pu_step), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_winner", int'(winner), 0);
        checkOutput("rst_error", int'(error), 0);
        checkOutput("rst_iter", int'(iter_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fill_seq(4'b0000); cur_seq[0] = 4'b1011;
        applyStimulus(1'b0);
        fill_seq(4'b0000); cur_seq[2] = 4'b1110;
        applyStimulus(1'b0);
        fill_seq(4'b1111); cur_seq[0] = 4'b0001;
        applyStimulus(1'b0);
        fill_seq(4'b0000);
        applyStimulus(1'b0);
        fill_seq(4'b0011); cur_seq[MAX_ITER] = 4'b0111;
        applyStimulus(1'b0);
        fill_seq(4'b0000); cur_seq[MAX_ITER] = 4'b1111;
        applyStimulus(1'b0);
        fill_seq(4'b0000); cur_seq[0] = 4'b1101;
        applyStimulus(1'b1);
        fill_seq(4'b0000); cur_seq[1] = 4'b1110;
        applyStimulus(1'b0);

        resetMidRound();

        for (int n = 0; n < 40; n++) begin
            random_seq();
            applyStimulus(($urandom_range(0, 3) == 0));
        end

        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
